// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the radix-2 pipelined FFT front end.
//   FFT_N    - frame length in points (power of two, >= 4)
//   SAMPLE_W - real sample width, signed two's complement
//   IDX_W    - twiddle index width, log2(FFT_N)
//   state_e  - input commutator phase: FILL buffers the first half-frame,
//              PAIR emits (x[k], x[k+N/2], k) pairs.
package fft_pkg;
  localparam int FFT_N    = 8;
  localparam int SAMPLE_W = 8;
  localparam int IDX_W    = $clog2(FFT_N);

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_e;
endpackage

// File: rtl/fft_delay_buf.sv
// fft_delay_buf: DEPTH x W register file holding the first half of an FFT
// frame. One synchronous write port, one asynchronous read port. The array
// has no reset; its contents are only read after being written in the
// current frame.
//   clk     - rising-edge clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - read data (combinational)
module fft_delay_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data
);

  logic signed [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft_pair_feeder.sv
// fft_pair_feeder: input commutator for a radix-2 pipelined FFT. Accepts one
// real sample per cycle in natural order, buffers x[0..N/2-1], and as
// x[N/2..N-1] arrive emits registered pairs (x[k], x[k+N/2], k) to the
// 2-point butterfly stage.
//   clk, rst_n         - clock, asynchronous active-low reset
//   s_valid/s_ready    - input sample handshake
//   s_data, s_last     - sample and end-of-frame marker
//   m_valid/m_ready    - output pair handshake
//   m_in1, m_in2       - x[k], x[k+N/2]
//   m_index            - twiddle index k (0..N/2-1)
//   frame_err          - one-cycle pulse when s_last is misaligned
module fft_pair_feeder
  import fft_pkg::state_e, fft_pkg::FILL, fft_pkg::PAIR;
#(
  parameter int N     = fft_pkg::FFT_N,
  parameter int W     = fft_pkg::SAMPLE_W,
  parameter int IDX_W = fft_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_in1,
  output logic signed [W-1:0] m_in2,
  output logic [IDX_W-1:0]    m_index,
  output logic                frame_err
);

  localparam int HALF = N / 2;
  localparam int AW   = IDX_W - 1;

  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                m_valid_q, m_valid_d;
  logic signed [W-1:0] m_in1_q, m_in1_d;
  logic signed [W-1:0] m_in2_q, m_in2_d;
  logic [IDX_W-1:0]    m_index_q, m_index_d;
  logic                frame_err_q, frame_err_d;

  state_e              state;
  logic                accept;
  logic                last_pos;
  logic                buf_we;
  logic signed [W-1:0] buf_rd;

  // The phase is the counter MSB: the upper half of cnt is PAIR.
  always_comb begin
    state = FILL;
    if (cnt_q[IDX_W-1]) begin
      state = PAIR;
    end
  end

  assign last_pos = (cnt_q == IDX_W'(N - 1));
  assign s_ready  = (state == FILL) || !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;
  assign buf_we   = accept && (state == FILL);

  // Low counter bits address both the write (FILL) and the read (PAIR),
  // since cnt - N/2 in PAIR is just cnt with its MSB cleared.
  fft_delay_buf #(
    .DEPTH (HALF),
    .W     (W),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_data (s_data),
    .rd_addr (cnt_q[AW-1:0]),
    .rd_data (buf_rd)
  );

  always_comb begin
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_in1_d     = m_in1_q;
    m_in2_d     = m_in2_q;
    m_index_d   = m_index_q;
    frame_err_d = 1'b0;

    if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      // Early or missing s_last both flag an error; either way the frame
      // restarts at x[0], abandoning any partially buffered half-frame.
      frame_err_d = (s_last != last_pos);
      if (s_last || last_pos) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end

      if (state == PAIR) begin
        m_valid_d = 1'b1;
        m_in1_d   = buf_rd;
        m_in2_d   = s_data;
        m_index_d = {1'b0, cnt_q[AW-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_in1_q     <= '0;
      m_in2_q     <= '0;
      m_index_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_in1_q     <= m_in1_d;
      m_in2_q     <= m_in2_d;
      m_index_q   <= m_index_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_in1     = m_in1_q;
  assign m_in2     = m_in2_q;
  assign m_index   = m_index_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/fft_pair_feeder.md
# fft_pair_feeder

Input commutator for the radix-2 pipelined FFT, sitting directly upstream of the 2-point butterfly stage. It accepts one real sample per cycle in natural order and buffers the first half of each N-point frame. As the second half arrives, it emits one registered pair per accepted sample: in1 = x[k], in2 = x[k+N/2], plus the twiddle index k. The butterfly's ports (in1, in2, index) are driven directly from its output registers.

## Interface
- N, default 8: frame length in points; power of two, at least 4.
- W, default 8: sample width in bits, signed two's complement.
- IDX_W, default 3: width of index; equals log2(N).
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- s_valid, input, 1: input sample valid.
- s_ready, output, 1: block can accept a sample this cycle.
- s_data, input, W: input sample.
- s_last, input, 1: marks sample N-1 of a frame.
- m_valid, output, 1: output pair valid.
- m_ready, input, 1: butterfly stage accepts the pair.
- m_in1, output, W: x[k], signed.
- m_in2, output, W: x[k+N/2], signed.
- m_index, output, IDX_W: twiddle index k, range 0..N/2-1, MSB always 0.
- frame_err, output, 1: one-cycle pulse on an s_last misalignment.

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. Data is held stable while valid is high and ready is low.
- Position counter cnt counts 0..N-1 and advances on each accepted input.
- The state machine is derived from cnt:
  - FILL when cnt < N/2.
  - PAIR when cnt >= N/2.
- FILL:
  - s_ready = 1.
  - An accepted sample is written to buf[cnt].
  - Output registers are untouched, so a pending pair can still drain.
- PAIR:
  - s_ready = !m_valid || m_ready.
  - An accepted sample loads m_in1 = buf[cnt-N/2], m_in2 = s_data, m_index = cnt-N/2, and sets m_valid.
- m_valid clears when m_ready is high and no new pair loads in the same cycle.
- Wrap-around: accepting sample N-1 returns cnt to 0 and the machine to FILL.
- Early s_last (accepted with cnt != N-1):
  - frame_err pulses.
  - If the beat is in PAIR, its pair is still emitted.
  - cnt returns to 0, and the buffered half-frame is abandoned.
- Missing s_last (sample N-1 accepted without it): frame_err pulses and the block wraps normally.
- No arithmetic is performed; samples pass through bit-exact.

## Timing
- Reset values:
  - m_valid = 0, m_in1 = 0, m_in2 = 0, m_index = 0, frame_err = 0.
  - cnt = 0, state FILL.
  - buf contents are don't-care.
- s_ready during reset is 1, consistent with the FILL state.
- Latency: a pair is visible on m_* one cycle after the sample x[k+N/2] is accepted.
- Throughput: one sample per cycle sustained when m_ready is held high. With N=8, a full frame takes 8 input cycles and produces 4 pairs.
- m_ready low in PAIR stalls input with no loss. Simultaneous pair drain and new load in one cycle is allowed.
- Reset asserted mid-frame:
  - All registers clear immediately, without waiting for a clock edge.
  - Any pending pair is dropped.
  - The next accepted sample is treated as x[0].
- frame_err is high for exactly one cycle, the cycle after the offending beat is accepted.

## Structure
- Shared package fft_pkg holds:
  - The FFT_N, SAMPLE_W and IDX_W constants, shared with the butterfly stage.
  - The state enum {FILL, PAIR}.
- One sub-module, fft_delay_buf: an N/2 x W register file with one write port and one asynchronous read port. It has no reset on the data.
- Counter, handshake, output registers and error logic live in fft_pair_feeder.

## Test plan
- Basic frame: N=8, stream 1..8 with m_ready=1 and s_last on 8. Expect pairs (1,5,0), (2,6,1), (3,7,2), (4,8,3), one per cycle starting one cycle after sample 5 is accepted. frame_err stays 0.
- Back-to-back frames: stream 1..8 then 9..16. Expect 8 pairs in total; the second frame gives (9,13,0)..(12,16,3) with no gaps or corruption.
- Backpressure: hold m_ready=0 for 3 cycles while in PAIR. Expect s_ready=0, m_in1/m_in2/m_index held stable, and no pair lost or duplicated.
- Signed data: input -128, -1, 127, 0, 5, -5, 64, -64. Expect pairs (-128,5,0), (-1,-5,1), (127,64,2), (0,-64,3), bit-exact.
- Early s_last on sample 6 (the value 6 in stream 1..6):
  - Pairs (1,5,0) and (2,6,1) are emitted.
  - frame_err pulses once.
  - The next inputs 21..28 yield (21,25,0)..(24,28,3).
- Reset mid-frame:
  - Drop rst_n after 6 samples; all outputs go to 0 immediately.
  - After release, 1..8 yields the four basic-frame pairs.
